// File: rtl/strm_trailer_insert_if.sv
// ---------------------------------------------------------------------------
// strm_trailer_insert_if
// AXI4-Stream style bundle used on both sides of strm_trailer_insert.
//   tvalid  : beat valid (master -> slave)
//   tready  : beat accepted when tvalid & tready (slave -> master)
//   tdata   : DATA_BITS payload
//   tkeep   : one bit per payload byte
//   tlast   : last beat of packet
//   tid     : PID_BITS process ID
// ---------------------------------------------------------------------------
interface strm_trailer_insert_if #(
    parameter int DATA_BITS = 512,
    parameter int PID_BITS  = 6
);
    logic                   tvalid;
    logic                   tready;
    logic [DATA_BITS-1:0]   tdata;
    logic [DATA_BITS/8-1:0] tkeep;
    logic                   tlast;
    logic [PID_BITS-1:0]    tid;

    modport master (output tvalid, tdata, tkeep, tlast, tid, input tready);
    modport slave  (input tvalid, tdata, tkeep, tlast, tid, output tready);
endinterface

// File: rtl/strm_trailer_insert.sv
// ---------------------------------------------------------------------------
// strm_trailer_insert
// Forwards a packet stream through one output register and, for packets whose
// en_trailer was high on their first beat, appends a trailer beat carrying
// the packet byte count, an XOR checksum of its 32-bit lanes and a sequence
// number (packets completed before this one started).
//   aclk, aresetn : clock, asynchronous active-low reset
//   s_axis        : upstream stream (slave)
//   m_axis        : downstream stream (master), registered
//   en_trailer    : trailer enable, sampled on each packet's first beat
//   pkt_cnt       : packets (beats with tlast) consumed at the output
// ---------------------------------------------------------------------------
module strm_trailer_insert #(
    parameter int DATA_BITS = 512,
    parameter int PID_BITS  = 6
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    strm_trailer_insert_if.slave  s_axis,
    strm_trailer_insert_if.master m_axis,
    input  logic                  en_trailer,
    output logic [31:0]           pkt_cnt
);
    localparam int KEEP_BITS = DATA_BITS / 8;
    localparam int LANES     = DATA_BITS / 32;

    localparam logic [0:0] PASS  = 1'b0;
    localparam logic [0:0] TRAIL = 1'b1;

    logic [0:0]           state_q, state_d;
    logic                 rdy_q;
    logic                 vld_q, vld_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic [KEEP_BITS-1:0] keep_q, keep_d;
    logic                 last_q, last_d;
    logic [PID_BITS-1:0]  tid_q, tid_d;
    logic                 in_pkt_q, in_pkt_d;
    logic                 en_q, en_d;
    logic [31:0]          byte_cnt_q, byte_cnt_d;
    logic [31:0]          csum_q, csum_d;
    logic [31:0]          seq_q, seq_d;
    logic [PID_BITS-1:0]  ptid_q, ptid_d;
    logic [31:0]          pkt_cnt_q, pkt_cnt_d;

    logic                 s_ready, acc, first, en_eff, out_take;
    logic [31:0]          beat_bytes, beat_csum;
    logic [DATA_BITS-1:0] masked;

    // Per-beat byte count and lane checksum with unkept bytes zeroed.
    always_comb begin
        beat_bytes = '0;
        beat_csum  = '0;
        masked     = '0;
        for (int b = 0; b < KEEP_BITS; b++) begin
            masked[b*8 +: 8] = s_axis.tkeep[b] ? s_axis.tdata[b*8 +: 8] : 8'h00;
            beat_bytes       = beat_bytes + 32'(s_axis.tkeep[b]);
        end
        for (int l = 0; l < LANES; l++)
            beat_csum = beat_csum ^ masked[l*32 +: 32];
    end

    // rdy_q keeps tready low until the first edge after reset release.
    assign out_take = vld_q && m_axis.tready;
    assign s_ready  = rdy_q && (state_q == PASS) && (!vld_q || m_axis.tready);
    assign acc      = s_axis.tvalid && s_ready;
    assign first    = !in_pkt_q;
    assign en_eff   = first ? en_trailer : en_q;

    always_comb begin
        state_d    = state_q;
        vld_d      = vld_q;
        data_d     = data_q;
        keep_d     = keep_q;
        last_d     = last_q;
        tid_d      = tid_q;
        in_pkt_d   = in_pkt_q;
        en_d       = en_q;
        byte_cnt_d = byte_cnt_q;
        csum_d     = csum_q;
        seq_d      = seq_q;
        ptid_d     = ptid_q;
        pkt_cnt_d  = pkt_cnt_q;

        if (out_take) begin
            vld_d = 1'b0;
            if (last_q) pkt_cnt_d = pkt_cnt_q + 32'd1;
        end

        if (state_q == TRAIL) begin
            if (!vld_q || m_axis.tready) begin
                vld_d          = 1'b1;
                data_d         = '0;
                data_d[95:0]   = {seq_q, csum_q, byte_cnt_q};
                keep_d         = '0;
                keep_d[11:0]   = 12'hFFF;
                last_d         = 1'b1;
                tid_d          = ptid_q;
                state_d        = PASS;
            end
        end else if (acc) begin
            vld_d      = 1'b1;
            data_d     = s_axis.tdata;
            keep_d     = s_axis.tkeep;
            last_d     = s_axis.tlast && !en_eff;
            tid_d      = s_axis.tid;
            in_pkt_d   = !s_axis.tlast;
            byte_cnt_d = (first ? 32'd0 : byte_cnt_q) + beat_bytes;
            csum_d     = (first ? 32'd0 : csum_q) ^ beat_csum;
            if (first) begin
                en_d   = en_trailer;
                // pkt_cnt_d already includes a tlast consumed this cycle.
                seq_d  = pkt_cnt_d;
                ptid_d = s_axis.tid;
            end
            if (s_axis.tlast && en_eff) state_d = TRAIL;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= PASS;
            rdy_q      <= 1'b0;
            vld_q      <= 1'b0;
            data_q     <= '0;
            keep_q     <= '0;
            last_q     <= 1'b0;
            tid_q      <= '0;
            in_pkt_q   <= 1'b0;
            en_q       <= 1'b0;
            byte_cnt_q <= '0;
            csum_q     <= '0;
            seq_q      <= '0;
            ptid_q     <= '0;
            pkt_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            rdy_q      <= 1'b1;
            vld_q      <= vld_d;
            data_q     <= data_d;
            keep_q     <= keep_d;
            last_q     <= last_d;
            tid_q      <= tid_d;
            in_pkt_q   <= in_pkt_d;
            en_q       <= en_d;
            byte_cnt_q <= byte_cnt_d;
            csum_q     <= csum_d;
            seq_q      <= seq_d;
            ptid_q     <= ptid_d;
            pkt_cnt_q  <= pkt_cnt_d;
        end
    end

    assign s_axis.tready = s_ready;
    assign m_axis.tvalid = vld_q;
    assign m_axis.tdata  = data_q;
    assign m_axis.tkeep  = keep_q;
    assign m_axis.tlast  = last_q;
    assign m_axis.tid    = tid_q;
    assign pkt_cnt       = pkt_cnt_q;
endmodule

// File: tb/tb_strm_trailer_insert.sv
// ---------------------------------------------------------------------------
// tb_strm_trailer_insert
// Directed and randomized packets against a packet-level reference model:
// expected beats and trailers are derived from byte sums and byte-wise XOR.
// ---------------------------------------------------------------------------
module tb_strm_trailer_insert;
    localparam int DB = 512;
    localparam int PB = 6;
    localparam int KB = DB / 8;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        en_trailer = 1'b0;
    logic [31:0] pkt_cnt;

    strm_trailer_insert_if #(.DATA_BITS(DB), .PID_BITS(PB)) s_if ();
    strm_trailer_insert_if #(.DATA_BITS(DB), .PID_BITS(PB)) m_if ();

    strm_trailer_insert #(.DATA_BITS(DB), .PID_BITS(PB)) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .s_axis     (s_if),
        .m_axis     (m_if),
        .en_trailer (en_trailer),
        .pkt_cnt    (pkt_cnt)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [DB-1:0] d;
        logic [KB-1:0] k;
        logic          l;
        logic [PB-1:0] id;
        int            cyc;
    } beat_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    beat_t       pkt[$];
    beat_t       exp_q[$];
    beat_t       got_q[$];
    int unsigned model_pkts = 0;
    bit          bp_on = 1'b0;
    int          cyc = 0;
    int          stall_err = 0;

    initial begin
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tkeep  = '0;
        s_if.tlast  = 1'b0;
        s_if.tid    = '0;
        m_if.tready = 1'b1;
    end

    initial forever begin
        @(posedge aclk);
        cyc = cyc + 1;
        #1;
        m_if.tready = bp_on ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    // Output monitor: captures transfers, flags changes while stalled.
    initial begin : monitor
        beat_t prev;
        bit    prev_stall;
        prev_stall = 1'b0;
        forever begin
            @(negedge aclk);
            if (!aresetn) prev_stall = 1'b0;
            else begin
                if (prev_stall && (m_if.tvalid !== 1'b1 || m_if.tdata !== prev.d ||
                    m_if.tkeep !== prev.k || m_if.tlast !== prev.l || m_if.tid !== prev.id))
                    stall_err++;
                prev.d = m_if.tdata; prev.k = m_if.tkeep;
                prev.l = m_if.tlast; prev.id = m_if.tid; prev.cyc = cyc;
                if (m_if.tvalid && m_if.tready) got_q.push_back(prev);
                prev_stall = m_if.tvalid && !m_if.tready;
            end
        end
    end

    // Reference: a packet becomes its beats (tlast cleared when a trailer
    // follows) plus a trailer computed from the bytes it kept.
    task automatic model_pkt(input bit en);
        int unsigned bytes = 0;
        logic [31:0] cs = '0;
        beat_t e, t;
        foreach (pkt[i]) begin
            e = pkt[i];
            if (en) e.l = 1'b0;
            exp_q.push_back(e);
            for (int b = 0; b < KB; b++)
                if (pkt[i].k[b]) begin
                    bytes++;
                    cs = cs ^ (32'(pkt[i].d[8*b +: 8]) << (8 * (b % 4)));
                end
        end
        if (en) begin
            t.d = '0;
            t.d[31:0]  = bytes;
            t.d[63:32] = cs;
            t.d[95:64] = model_pkts;
            t.k = KB'(12'hFFF);
            t.l = 1'b1;
            t.id = pkt[0].id;
            t.cyc = 0;
            exp_q.push_back(t);
        end
        model_pkts++;
    endtask

    task automatic build_rand(input int n, input logic [PB-1:0] id);
        beat_t b;
        pkt.delete();
        for (int i = 0; i < n; i++) begin
            for (int l = 0; l < DB / 32; l++) b.d[32*l +: 32] = $urandom;
            case ($urandom_range(0, 3))
                0: b.k = '1;
                1: b.k = '0;
                default: for (int w = 0; w < KB / 32; w++) b.k[32*w +: 32] = $urandom;
            endcase
            b.l = (i == n - 1);
            b.id = id;
            b.cyc = 0;
            pkt.push_back(b);
        end
    endtask

    task automatic drive_pkt(input bit en, input int max_beats, output bit to);
        bit acc;
        int w;
        to = 1'b0;
        for (int i = 0; i < pkt.size() && i < max_beats; i++) begin
            s_if.tvalid = 1'b1;
            s_if.tdata  = pkt[i].d;
            s_if.tkeep  = pkt[i].k;
            s_if.tlast  = pkt[i].l;
            s_if.tid    = pkt[i].id;
            en_trailer  = (i == 0) ? en : 1'($urandom_range(0, 1));
            acc = 1'b0;
            w = 0;
            while (!acc && w < 200) begin
                @(negedge aclk);
                acc = s_if.tready;
                @(posedge aclk);
                #1;
                w++;
            end
            if (!acc) to = 1'b1;
        end
        s_if.tvalid = 1'b0;
    endtask

    task automatic drain(output bit to);
        int w = 0;
        while (got_q.size() < exp_q.size() && w < 3000) begin
            @(posedge aclk);
            w++;
        end
        repeat (3) @(posedge aclk);
        #1;
        to = (got_q.size() != exp_q.size());
    endtask

    task automatic do_reset();
        s_if.tvalid = 1'b0;
        aresetn = 1'b0;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        model_pkts = 0;
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_reset();
        #12;
        n_cmp++;
        if (m_if.tvalid !== 1'b0 || s_if.tready !== 1'b0 || m_if.tdata !== '0 ||
            m_if.tkeep !== '0 || m_if.tlast !== 1'b0 || m_if.tid !== '0 || pkt_cnt !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got vld=%b rdy=%b last=%b id=%h cnt=%0d, want all zero",
                     m_if.tvalid, s_if.tready, m_if.tlast, m_if.tid, pkt_cnt);
        end
        @(negedge aclk);
        aresetn = 1'b1;
        #1;
        n_cmp++;
        if (s_if.tready !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release_ready: got %b, want 0 before first edge", s_if.tready);
        end
        @(posedge aclk);
        #1;
        n_cmp++;
        if (s_if.tready !== 1'b1) begin
            n_bad++;
            $display("FAIL ready_after_edge: got %b, want 1", s_if.tready);
        end
    endtask

    task automatic test_two_beat();
        bit to;
        beat_t b;
        pkt.delete();
        for (int i = 0; i < 2; i++) begin
            for (int l = 0; l < DB / 32; l++) b.d[32*l +: 32] = 32'h1;
            b.k = '1; b.l = (i == 1); b.id = 6'd3; b.cyc = 0;
            pkt.push_back(b);
        end
        model_pkt(1'b1);
        drive_pkt(1'b1, 99, to);
        drain(to);
        n_cmp++;
        if (to) begin n_bad++; $display("FAIL two_beat_count: got %0d beats, want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i].d !== exp_q[i].d || got_q[i].k !== exp_q[i].k || got_q[i].l !== exp_q[i].l || got_q[i].id !== exp_q[i].id) begin
                n_bad++;
                $display("FAIL two_beat[%0d]: got d=%h k=%h l=%b id=%h, want d=%h k=%h l=%b id=%h", i,
                         got_q[i].d, got_q[i].k, got_q[i].l, got_q[i].id, exp_q[i].d, exp_q[i].k, exp_q[i].l, exp_q[i].id);
            end
        end
        if (got_q.size() == 3) begin
            n_cmp++;
            if (got_q[2].d[95:0] !== {32'd0, 32'd0, 32'd128} || {got_q[0].l, got_q[1].l, got_q[2].l} !== 3'b001 || got_q[2].id !== 6'd3) begin
                n_bad++;
                $display("FAIL two_beat_trailer: got %h last=%b%b%b, want bytes=128 csum=0 seq=0 last=001",
                         got_q[2].d[95:0], got_q[0].l, got_q[1].l, got_q[2].l);
            end
        end
        n_cmp++;
        if (pkt_cnt !== 32'd1) begin n_bad++; $display("FAIL two_beat_pkt_cnt: got %0d, want 1", pkt_cnt); end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_small_keep();
        bit to;
        build_rand(1, 6'd17);
        pkt[0].k = KB'(4'hF);
        pkt[0].d[31:0] = 32'hDEADBEEF;
        model_pkt(1'b1);
        drive_pkt(1'b1, 99, to);
        drain(to);
        n_cmp++;
        if (to) begin n_bad++; $display("FAIL small_count: got %0d beats, want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i].d !== exp_q[i].d || got_q[i].k !== exp_q[i].k || got_q[i].l !== exp_q[i].l || got_q[i].id !== exp_q[i].id) begin
                n_bad++;
                $display("FAIL small[%0d]: got d=%h k=%h l=%b, want d=%h k=%h l=%b", i,
                         got_q[i].d, got_q[i].k, got_q[i].l, exp_q[i].d, exp_q[i].k, exp_q[i].l);
            end
        end
        if (got_q.size() == 2) begin
            n_cmp++;
            if (got_q[1].d[95:0] !== {32'd1, 32'hDEADBEEF, 32'd4}) begin
                n_bad++;
                $display("FAIL small_trailer: got %h, want seq=1 csum=deadbeef bytes=4", got_q[1].d[95:0]);
            end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_no_trailer();
        bit to;
        build_rand(3, 6'd9);
        foreach (pkt[i]) pkt[i].k = '1;
        model_pkt(1'b0);
        drive_pkt(1'b0, 99, to);
        drain(to);
        n_cmp++;
        if (to) begin n_bad++; $display("FAIL notrail_count: got %0d beats, want 3", got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i].d !== exp_q[i].d || got_q[i].k !== exp_q[i].k || got_q[i].l !== exp_q[i].l || got_q[i].id !== exp_q[i].id) begin
                n_bad++;
                $display("FAIL notrail[%0d]: got d=%h l=%b, want d=%h l=%b", i, got_q[i].d, got_q[i].l, exp_q[i].d, exp_q[i].l);
            end
        end
        n_cmp++;
        if (pkt_cnt !== 32'd3) begin n_bad++; $display("FAIL notrail_pkt_cnt: got %0d, want 3", pkt_cnt); end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_back_to_back();
        bit to, to2, gap;
        do_reset();
        bp_on = 1'b0;
        for (int p = 0; p < 2; p++) begin
            build_rand($urandom_range(1, 3), PB'(p + 5));
            model_pkt(1'b1);
            drive_pkt(1'b1, 99, to);
        end
        drain(to2);
        n_cmp++;
        if (to || to2) begin n_bad++; $display("FAIL b2b_count: got %0d beats, want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i].d !== exp_q[i].d || got_q[i].k !== exp_q[i].k || got_q[i].l !== exp_q[i].l || got_q[i].id !== exp_q[i].id) begin
                n_bad++;
                $display("FAIL b2b[%0d]: got d=%h l=%b id=%h, want d=%h l=%b id=%h", i,
                         got_q[i].d, got_q[i].l, got_q[i].id, exp_q[i].d, exp_q[i].l, exp_q[i].id);
            end
        end
        gap = 1'b0;
        for (int i = 1; i < got_q.size(); i++)
            if (got_q[i].cyc != got_q[i-1].cyc + 1) gap = 1'b1;
        n_cmp++;
        if (gap) begin n_bad++; $display("FAIL b2b_bubble: got gap in output, want continuous transfers"); end
        if (got_q.size() > 0) begin
            n_cmp++;
            if (got_q[got_q.size()-1].d[95:64] !== 32'd1) begin
                n_bad++;
                $display("FAIL b2b_seq: got %0d, want 1", got_q[got_q.size()-1].d[95:64]);
            end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_backpressure();
        bit to, any_to;
        bit en;
        any_to = 1'b0;
        bp_on = 1'b1;
        stall_err = 0;
        for (int p = 0; p < 100; p++) begin
            en = 1'($urandom_range(0, 1));
            build_rand($urandom_range(1, 4), PB'($urandom));
            model_pkt(en);
            drive_pkt(en, 99, to);
            if (to) any_to = 1'b1;
            repeat ($urandom_range(0, 2)) @(posedge aclk);
            #1;
        end
        drain(to);
        bp_on = 1'b0;
        n_cmp++;
        if (to || any_to) begin n_bad++; $display("FAIL bp_count: got %0d beats, want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i].d !== exp_q[i].d || got_q[i].k !== exp_q[i].k || got_q[i].l !== exp_q[i].l || got_q[i].id !== exp_q[i].id) begin
                n_bad++;
                $display("FAIL bp[%0d]: got d=%h k=%h l=%b id=%h, want d=%h k=%h l=%b id=%h", i,
                         got_q[i].d, got_q[i].k, got_q[i].l, got_q[i].id, exp_q[i].d, exp_q[i].k, exp_q[i].l, exp_q[i].id);
            end
        end
        n_cmp++;
        if (stall_err !== 0) begin n_bad++; $display("FAIL bp_stable: got %0d changes while stalled, want 0", stall_err); end
        n_cmp++;
        if (pkt_cnt !== model_pkts) begin n_bad++; $display("FAIL bp_pkt_cnt: got %0d, want %0d", pkt_cnt, model_pkts); end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_reset_mid();
        bit to, to2;
        build_rand(3, 6'd21);
        drive_pkt(1'b1, 1, to);
        aresetn = 1'b0;
        #1;
        n_cmp++;
        if (m_if.tvalid !== 1'b0 || pkt_cnt !== 32'd0 || s_if.tready !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_async: got vld=%b cnt=%0d rdy=%b, want 0 0 0", m_if.tvalid, pkt_cnt, s_if.tready);
        end
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        model_pkts = 0;
        exp_q.delete(); got_q.delete();
        build_rand(2, 6'd22);
        model_pkt(1'b1);
        drive_pkt(1'b1, 99, to);
        drain(to2);
        n_cmp++;
        if (to || to2) begin n_bad++; $display("FAIL midreset_count: got %0d beats, want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i].d !== exp_q[i].d || got_q[i].k !== exp_q[i].k || got_q[i].l !== exp_q[i].l || got_q[i].id !== exp_q[i].id) begin
                n_bad++;
                $display("FAIL midreset[%0d]: got d=%h l=%b, want d=%h l=%b", i, got_q[i].d, got_q[i].l, exp_q[i].d, exp_q[i].l);
            end
        end
        if (got_q.size() == 3) begin
            n_cmp++;
            if (got_q[2].d[95:64] !== 32'd0) begin
                n_bad++;
                $display("FAIL midreset_seq: got %0d, want 0", got_q[2].d[95:64]);
            end
        end
        exp_q.delete(); got_q.delete();
    endtask

    initial begin
        test_reset();
        test_two_beat();
        test_small_keep();
        test_no_trailer();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
